serial_parity_rx: RTL and testbench



---
 rtl/serial_parity_pkg.sv | 6 +
 rtl/serial_parity_rx_parity_calc9.sv | 18 +
 rtl/serial_parity_rx.sv | 83 ++++++++
 tb/tb_serial_parity_rx.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/serial_parity_pkg.sv
// serial_parity_pkg: shared constants and state encoding for the 9-bit parity receiver.
package serial_parity_pkg;
    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 11;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
endpackage

// File: rtl/serial_parity_rx_parity_calc9.sv
// parity_calc9: balanced XOR tree over 8 data bits plus the parity bit.
// o_even_err is the error flag for even parity, o_odd_err for odd parity.
module parity_calc9 (
    input  logic [7:0] i_data,
    input  logic       i_par,
    output logic       o_even_err,
    output logic       o_odd_err
);
    logic [3:0] w_p;
    logic [1:0] w_q;
    logic       w_r;

    assign w_p = {i_data[7] ^ i_data[6], i_data[5] ^ i_data[4], i_data[3] ^ i_data[2], i_data[1] ^ i_data[0]};
    assign w_q = {w_p[3] ^ w_p[2], w_p[1] ^ w_p[0]};
    assign w_r = w_q[1] ^ w_q[0];
    assign o_even_err = w_r ^ i_par;
    assign o_odd_err  = w_r ~^ i_par;
endmodule

// File: rtl/serial_parity_rx.sv
// serial_parity_rx: start/8 data/parity/stop deserialiser with parity and framing checks,
// presenting each byte on a valid/ready port that holds until accepted.
module serial_parity_rx #(
    parameter bit ODD_PARITY = 1'b0,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              rx_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_perr,
    output logic              out_ferr,
    output logic              overrun,
    output logic              busy
);
    import serial_parity_pkg::*;

    state_t            r_state, w_next;
    logic [2:0]        r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_par;
    logic              w_even_err, w_odd_err, w_perr, w_done, w_load;

    parity_calc9 u_par (
        .i_data     (r_shift),
        .i_par      (r_par),
        .o_even_err (w_even_err),
        .o_odd_err  (w_odd_err)
    );

    assign w_perr = ODD_PARITY ? w_odd_err : w_even_err;
    assign w_done = bit_en && (r_state == STOP);
    // A held byte blocks the new one unless it is being accepted this very cycle.
    assign w_load = w_done && (!out_valid || out_ready);
    assign busy   = r_state != IDLE;

    always_comb begin
        w_next = r_state;
        if (bit_en)
            case (r_state)
                IDLE:    w_next = rx_in ? IDLE : DATA;
                DATA:    w_next = (r_cnt == 3'(DATA_W - 1)) ? PARITY : DATA;
                PARITY:  w_next = STOP;
                default: w_next = IDLE;
            endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_perr  <= 1'b0;
            out_ferr  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (bit_en && r_state == IDLE) r_cnt <= '0;
            if (bit_en && r_state == DATA) begin
                r_shift[r_cnt] <= rx_in;
                r_cnt          <= r_cnt + 3'd1;
            end
            if (bit_en && r_state == PARITY) r_par <= rx_in;
            overrun <= w_done && out_valid && !out_ready;
            if (w_load) begin
                out_data  <= r_shift;
                out_perr  <= w_perr;
                out_ferr  <= !rx_in;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_serial_parity_rx.sv
// tb_serial_parity_rx: directed frames with hand-computed results; an even and an odd
// parity receiver share the same serial line and handshake.
module tb_serial_parity_rx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_en = 1'b0;
    logic       rx_in = 1'b1;
    logic       out_ready = 1'b0;
    logic [7:0] out_data, o_data;
    logic       out_valid, out_perr, out_ferr, overrun, busy;
    logic       o_valid, o_perr, o_ferr, o_overrun, o_busy;
    int         errors = 0;
    int         checks = 0;
    int         gap = 0;

    always #5 clk = ~clk;

    serial_parity_rx #(.ODD_PARITY(1'b0)) u_even (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx_in(rx_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_perr(out_perr), .out_ferr(out_ferr), .overrun(overrun), .busy(busy)
    );

    serial_parity_rx #(.ODD_PARITY(1'b1)) u_odd (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx_in(rx_in),
        .out_data(o_data), .out_valid(o_valid), .out_ready(out_ready),
        .out_perr(o_perr), .out_ferr(o_ferr), .overrun(o_overrun), .busy(o_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One bit_en strobe; returns 1 time unit after the sampling edge.
    task automatic strobe(input logic b);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_in  = b;
        bit_en = 1'b1;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
        rx_in  = 1'b1;
    endtask

    task automatic send_head(input logic [7:0] d, input logic par);
        strobe(1'b0);
        for (int i = 0; i < 8; i++) strobe(d[i]);
        strobe(par);
    endtask

    task automatic send(input logic [7:0] d, input logic par, input logic stop);
        send_head(d, par);
        strobe(stop);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_perr", out_perr, 0);
        chk("rst_ferr", out_ferr, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        out_ready = 1'b1;
        send(8'hA5, 1'b0, 1'b1);
        chk("a5_valid", out_valid, 1);
        chk("a5_data", out_data, 8'hA5);
        chk("a5_perr", out_perr, 0);
        chk("a5_ferr", out_ferr, 0);
        chk("a5_overrun", overrun, 0);
        chk("a5_odd_perr", o_perr, 1);
        chk("a5_busy", busy, 0);
        tick();
        chk("a5_accepted", out_valid, 0);

        send(8'h01, 1'b0, 1'b1);
        chk("p01_data", out_data, 8'h01);
        chk("p01_perr", out_perr, 1);
        chk("p01_ferr", out_ferr, 0);
        chk("p01_odd_data", o_data, 8'h01);
        chk("p01_odd_perr", o_perr, 0);
        tick();

        send(8'h3C, 1'b0, 1'b0);
        chk("f3c_valid", out_valid, 1);
        chk("f3c_data", out_data, 8'h3C);
        chk("f3c_ferr", out_ferr, 1);
        chk("f3c_perr", out_perr, 0);
        tick();
        gap = 2;
        send_head(8'h55, 1'b0);
        chk("f55_busy", busy, 1);
        strobe(1'b1);
        gap = 0;
        chk("f55_data", out_data, 8'h55);
        chk("f55_ferr", out_ferr, 0);
        chk("f55_perr", out_perr, 0);
        tick();

        out_ready = 1'b0;
        send(8'h11, 1'b0, 1'b1);
        chk("bp11_valid", out_valid, 1);
        chk("bp11_data", out_data, 8'h11);
        send(8'h22, 1'b0, 1'b1);
        chk("bp22_overrun", overrun, 1);
        chk("bp22_data", out_data, 8'h11);
        tick();
        chk("bp22_overrun_pulse", overrun, 0);
        chk("bp22_hold_valid", out_valid, 1);
        chk("bp22_hold_data", out_data, 8'h11);
        out_ready = 1'b1;
        tick();
        chk("bp_accepted", out_valid, 0);

        out_ready = 1'b0;
        send(8'h77, 1'b0, 1'b1);
        chk("b2b77_data", out_data, 8'h77);
        send_head(8'h88, 1'b0);
        out_ready = 1'b1;
        strobe(1'b1);
        chk("b2b88_valid", out_valid, 1);
        chk("b2b88_data", out_data, 8'h88);
        chk("b2b88_overrun", overrun, 0);
        tick();
        chk("b2b88_accepted", out_valid, 0);

        out_ready = 1'b0;
        send(8'h5A, 1'b0, 1'b1);
        chk("rst5a_valid", out_valid, 1);
        strobe(1'b0);
        for (int i = 0; i < 4; i++) strobe(1'b0);
        chk("midrst_busy_before", busy, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", out_data, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_perr", out_perr, 0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        gap = 1;
        send(8'h0F, 1'b0, 1'b1);
        gap = 0;
        chk("rst0f_valid", out_valid, 1);
        chk("rst0f_data", out_data, 8'h0F);
        chk("rst0f_perr", out_perr, 0);
        chk("rst0f_ferr", out_ferr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
